// File: rtl/obc_pkg.sv
// Shared types and constants for the OBC bit-plane interface.
package obc_pkg;

    localparam int N_PTS      = 16;
    localparam int DATA_W_DEF = 8;

    typedef logic [N_PTS-1:0]      plane_t;
    typedef logic [DATA_W_DEF-1:0] sample_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/obc_plane_extract.sv
// 16-way bit transpose: gathers bit i_idx of every sample in the frame into one plane.
module obc_plane_extract
    import obc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    localparam int IDX_W = $clog2(DATA_W)
) (
    input  logic [N_PTS*DATA_W-1:0] i_frame,
    input  logic [IDX_W-1:0]        i_idx,
    output plane_t                  o_plane
);

    logic [DATA_W-1:0] w_sample;

    // Pick the selected bit from each sample slice.
    always_comb begin
        o_plane  = '0;
        w_sample = '0;
        for (int k = 0; k < N_PTS; k++) begin
            w_sample   = i_frame[k*DATA_W +: DATA_W];
            o_plane[k] = w_sample[i_idx];
        end
    end

endmodule

// File: rtl/obc_bitplane_serializer.sv
// OBC bit-plane serializer: latches a 16-sample frame and emits one bit-plane per handshake.
// Build option OBC_SER_MSB_FIRST_EN switches emission order to MSB-first.
module obc_bitplane_serializer
    import obc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    localparam int IDX_W = $clog2(DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_PTS*DATA_W-1:0] in_data,
    output logic                    pl_valid,
    input  logic                    pl_ready,
    output logic [N_PTS-1:0]        pl_bits,
    output logic                    pl_m,
    output logic [IDX_W-1:0]        pl_idx,
    output logic                    pl_first,
    output logic                    pl_last
);

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(DATA_W - 1);

    ser_state_t              r_state;
    logic [N_PTS*DATA_W-1:0] r_frame;
    logic [IDX_W-1:0]        r_cnt;
    logic                    r_valid;
    plane_t                  r_bits;
    logic                    r_m;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_first;
    logic                    r_last;

    ser_state_t              w_state_nxt;
    logic [N_PTS*DATA_W-1:0] w_frame_nxt;
    logic [IDX_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_valid_nxt;
    plane_t                  w_plane_nxt;
    logic                    w_accept;
    logic                    w_pl_hs;

    // Ready in IDLE, or on the last plane's handshake so the next frame follows without a bubble.
    assign in_ready = (r_state == IDLE) | (r_last & pl_ready);
    assign w_accept = in_valid & in_ready;
    assign w_pl_hs  = r_valid & pl_ready;

    // Next-state, next-frame and next-counter selection.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_frame_nxt = in_data;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            SHIFT: begin
                if (w_accept) begin
                    w_frame_nxt = in_data;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b1;
                end else if (w_pl_hs && r_last) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (w_pl_hs) begin
                    w_cnt_nxt   = r_cnt + IDX_W'(1);
                end else begin
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Emission order maps the counter onto a bit position.
    always_comb begin
`ifdef OBC_SER_MSB_FIRST_EN
        w_idx_nxt = LAST_CNT - w_cnt_nxt;
`else
        w_idx_nxt = w_cnt_nxt;
`endif
    end

    obc_plane_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .i_frame (w_frame_nxt),
        .i_idx   (w_idx_nxt),
        .o_plane (w_plane_nxt)
    );

    // State, frame, counter and registered plane outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_bits  <= '0;
            r_m     <= 1'b0;
            r_idx   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_frame <= w_frame_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            if (w_valid_nxt) begin
                r_bits  <= w_plane_nxt;
                r_m     <= (w_idx_nxt == LAST_CNT);
                r_idx   <= w_idx_nxt;
                r_first <= (w_cnt_nxt == '0);
                r_last  <= (w_cnt_nxt == LAST_CNT);
            end else begin
                r_bits  <= '0;
                r_m     <= 1'b0;
                r_idx   <= '0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign pl_valid = r_valid;
    assign pl_bits  = r_bits;
    assign pl_m     = r_m;
    assign pl_idx   = r_idx;
    assign pl_first = r_first;
    assign pl_last  = r_last;

endmodule

// File: tb/tb_obc_bitplane_serializer.sv
// Scoreboard bench for obc_bitplane_serializer (DATA_W=8); honours OBC_SER_MSB_FIRST_EN.
module tb_obc_bitplane_serializer;

    localparam int DW = 8;
    localparam int NP = 16;
    localparam int FW = NP * DW;

    typedef struct packed {
        logic [NP-1:0] bits;
        logic          m;
        logic [2:0]    idx;
        logic          first;
        logic          last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_data;
    logic          pl_valid;
    logic          pl_ready;
    logic [NP-1:0] pl_bits;
    logic          pl_m;
    logic [2:0]    pl_idx;
    logic          pl_first;
    logic          pl_last;

    obc_bitplane_serializer #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .pl_valid (pl_valid),
        .pl_ready (pl_ready),
        .pl_bits  (pl_bits),
        .pl_m     (pl_m),
        .pl_idx   (pl_idx),
        .pl_first (pl_first),
        .pl_last  (pl_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            valid_cnt = 0;
    int            ir_cnt = 0;
    int            last_hs_cyc = 0;
    bit            last_acc = 1'b0;
    bit            log_en = 1'b0;
    exp_t          sb[$];
    logic [NP-1:0] obs_log[$];
    logic [NP-1:0] tbl[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [FW-1:0] d);
        exp_t e;
        int   idx;
        for (int c = 0; c < DW; c++) begin
`ifdef OBC_SER_MSB_FIRST_EN
            idx = DW - 1 - c;
`else
            idx = c;
`endif
            for (int k = 0; k < NP; k++) e.bits[k] = d[k*DW + idx];
            e.m     = (idx == DW - 1);
            e.idx   = 3'(idx);
            e.first = (c == 0);
            e.last  = (c == DW - 1);
            sb.push_back(e);
        end
    endtask

    // One clock: drive inputs after a negedge, observe stable outputs, account for the coming posedge.
    task automatic step(input logic v, input logic rdy, input logic [FW-1:0] d);
        exp_t e;
        cyc++;
        in_valid = v;
        pl_ready = rdy;
        in_data  = d;
        #1;
        last_acc = 1'b0;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (pl_valid) begin
                valid_cnt++;
                if (in_ready) ir_cnt++;
            end
            if (pl_valid && pl_ready) begin
                last_hs_cyc = cyc;
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("bits",  32'(pl_bits),  32'(e.bits));
                    chk("m",     32'(pl_m),     32'(e.m));
                    chk("idx",   32'(pl_idx),   32'(e.idx));
                    chk("first", 32'(pl_first), 32'(e.first));
                    chk("last",  32'(pl_last),  32'(e.last));
                end
                if (log_en) obs_log.push_back(pl_bits);
            end
            if (in_valid && in_ready) begin
                last_acc = 1'b1;
                push_frame(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (!pl_valid && sb.size() == 0) break;
            step(1'b0, 1'b1, '0);
        end
        chk("drain_idle", 32'(pl_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [FW-1:0] frame_k();
        logic [FW-1:0] f;
        for (int k = 0; k < NP; k++) f[k*DW +: DW] = 8'(k);
        return f;
    endfunction

    function automatic logic [FW-1:0] frame_rand();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [FW-1:0] fa;
        logic [FW-1:0] fb;
        int            ta;
`ifdef OBC_SER_MSB_FIRST_EN
        tbl = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};
`else
        tbl = '{16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
        rst_n    = 1'b0;
        in_valid = 1'b0;
        pl_ready = 1'b0;
        in_data  = '0;
        @(negedge clk);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("rst_valid", 32'(pl_valid), 32'd0);
        chk("rst_bits",  32'(pl_bits),  32'd0);
        chk("rst_idx",   32'(pl_idx),   32'd0);
        chk("rst_flags", 32'({pl_m, pl_first, pl_last}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_inready", 32'(in_ready), 32'd1);

        // Scenario 1: sample k = k, full throughput.
        log_en = 1'b1;
        obs_log.delete();
        step(1'b1, 1'b1, frame_k());
        chk("s1_latency", 32'(pl_valid), 32'd1);
`ifdef OBC_SER_MSB_FIRST_EN
        chk("s1_first_m", 32'(pl_m), 32'd1);
`else
        chk("s1_first_m", 32'(pl_m), 32'd0);
`endif
        drain();
        log_en = 1'b0;
        chk("s1_count", 32'(obs_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs_log.size()) chk("s1_plane", 32'(obs_log[i]), 32'(tbl[i]));
        end

        // Scenario 2: all ones, in_ready only on the last plane.
        ir_cnt = 0;
        step(1'b1, 1'b1, '1);
        drain();
        chk("s2_inready_once", 32'(ir_cnt), 32'd1);

        // Scenario 3: three-cycle stall at plane idx3.
        valid_cnt = 0;
        step(1'b1, 1'b1, frame_k());
        for (int i = 0; i < 20; i++) begin
            if (pl_valid && pl_idx == 3'd3) break;
            step(1'b0, 1'b1, '0);
        end
        for (int i = 0; i < 3; i++) begin
            chk("s3_hold_bits", 32'(pl_bits), 32'h0000FF00);
            chk("s3_hold_idx",  32'(pl_idx),  32'd3);
            step(1'b0, 1'b0, '0);
        end
        chk("s3_resume_bits", 32'(pl_bits), 32'h0000FF00);
        drain();
        chk("s3_duration", 32'(valid_cnt), 32'd11);

        // Scenario 4: two frames back-to-back with no bubble.
        fa = frame_rand();
        fb = frame_rand();
        ta = cyc + 1;
        step(1'b1, 1'b1, fa);
        chk("s4_a_acc", 32'(last_acc), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, fb);
            if (last_acc) break;
        end
        chk("s4_b_acc", 32'(last_acc), 32'd1);
        drain();
        chk("s4_span", 32'(last_hs_cyc - ta), 32'd16);

        // Scenario 5: reset mid-frame at idx4, then restart.
        step(1'b1, 1'b1, frame_rand());
        for (int i = 0; i < 20; i++) begin
            if (pl_valid && pl_idx == 3'd4) break;
            step(1'b0, 1'b1, '0);
        end
        chk("s5_reach", 32'(pl_idx), 32'd4);
        rst_n = 1'b0;
        step(1'b0, 1'b1, '0);
        rst_n = 1'b1;
        #1;
        chk("s5_valid", 32'(pl_valid), 32'd0);
        chk("s5_inready", 32'(in_ready), 32'd1);
        step(1'b1, 1'b1, frame_k());
        chk("s5_restart_first", 32'(pl_first), 32'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
